// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit: access modes, FSM states,
// access-size mask and mode validity.
package lsu_pkg;

    typedef enum logic [2:0] {
        MODE_NONE = 3'd0,
        MODE_W    = 3'd1,
        MODE_H    = 3'd2,
        MODE_B    = 3'd3,
        MODE_HU   = 3'd4,
        MODE_BU   = 3'd5
    } mode_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEAT0 = 2'd1;
    localparam logic [1:0] ST_BEAT1 = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic [3:0] size_mask(input logic [2:0] mode);
        case (mode)
            MODE_W:          return 4'hF;
            MODE_H, MODE_HU: return 4'h3;
            default:         return 4'h1;
        endcase
    endfunction

    function automatic logic mode_valid(input logic [2:0] mode);
        return (mode >= MODE_W) && (mode <= MODE_BU);
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load result formatting: shift the two-word read buffer down by the byte offset,
// then truncate to the access size with sign or zero extension.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [63:0] din,
    input  logic [1:0]  off,
    input  logic [2:0]  mode,
    output logic [31:0] dout
);

    logic [31:0] sh;

    always_comb begin
        sh = 32'(din >> {off, 3'b000});
        case (mode)
            MODE_B:  dout = {{24{sh[7]}}, sh[7:0]};
            MODE_BU: dout = {24'b0, sh[7:0]};
            MODE_H:  dout = {{16{sh[15]}}, sh[15:0]};
            MODE_HU: dout = {16'b0, sh[15:0]};
            default: dout = sh;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one core request into one or two word beats on a req/ack
// memory port, splitting accesses that cross a word boundary.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  we,
    input  logic [2:0]            modeBU,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    logic [1:0]              state;
    logic [1:0]              off;
    logic [7:0]              m8;
    logic [2*DATA_WIDTH-1:0] s64;

    logic [1:0]              lat_off;
    logic [2:0]              lat_mode;
    logic                    lat_we;
    logic [3:0]              lat_be_hi;
    logic [DATA_WIDTH-1:0]   lat_wd_hi;
    logic [DATA_WIDTH-1:0]   buf_lo;

    logic [2*DATA_WIDTH-1:0] ext_in;
    logic [DATA_WIDTH-1:0]   ext_out;

    assign off = addr[1:0];
    assign m8  = {4'b0, size_mask(modeBU)} << off;
    assign s64 = {{DATA_WIDTH{1'b0}}, wdata} << {off, 3'b000};

    // Extend the buffer as it will look after this ack, so rdata is valid together with done.
    assign ext_in = (state == ST_BEAT1) ? {mem_rdata, buf_lo} : {{DATA_WIDTH{1'b0}}, mem_rdata};

    lsu_extend u_extend (
        .din  (ext_in),
        .off  (lat_off),
        .mode (lat_mode),
        .dout (ext_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rdata     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0;
            mem_wdata <= '0;
            lat_off   <= 2'b0;
            lat_mode  <= MODE_NONE;
            lat_we    <= 1'b0;
            lat_be_hi <= 4'b0;
            lat_wd_hi <= '0;
            buf_lo    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && mode_valid(modeBU)) begin
                        lat_off   <= off;
                        lat_mode  <= modeBU;
                        lat_we    <= we;
                        lat_be_hi <= m8[7:4];
                        lat_wd_hi <= s64[2*DATA_WIDTH-1:DATA_WIDTH];
                        mem_req   <= 1'b1;
                        mem_we    <= we;
                        mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_be    <= m8[3:0];
                        mem_wdata <= s64[DATA_WIDTH-1:0];
                        busy      <= 1'b1;
                        state     <= ST_BEAT0;
                    end else if (start) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_BEAT0: begin
                    if (mem_ack) begin
                        buf_lo <= mem_rdata;
                        if (lat_be_hi != 4'b0) begin
                            mem_addr  <= mem_addr + ADDR_WIDTH'(4);
                            mem_be    <= lat_be_hi;
                            mem_wdata <= lat_wd_hi;
                            state     <= ST_BEAT1;
                        end else begin
                            mem_req <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            if (!lat_we) rdata <= ext_out;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_BEAT1: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        if (!lat_we) rdata <= ext_out;
                        state   <= ST_DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a table of single accesses with hand-computed
// beats and results, plus wait-state, start-while-busy and mid-beat reset sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        we;
    logic [2:0]  modeBU;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] prev_rdata = 32'h0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .we        (we),
        .modeBU    (modeBU),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one request; nwait = cycles without ack on beat0, poke = start pulse while busy.
    task automatic run_txn(input vec_t v, input int nwait, input bit poke);
        int nb;
        logic [31:0] ea;
        logic [3:0]  eb;
        logic [31:0] ew;
        nb = (v.be1 != 4'b0) ? 2 : 1;
        @(negedge clk);
        start = 1'b1; we = v.we; modeBU = v.mode; addr = v.addr; wdata = v.wdata;
        @(negedge clk);
        start = 1'b0;
        if (v.err) begin
            check("err_done", done, 1);
            check("err_flag", err, 1);
            check("err_noreq", mem_req, 0);
            check("err_busy", busy, 0);
            check("err_rdata", rdata, prev_rdata);
            @(negedge clk);
            check("err_done_pulse", done, 0);
            check("err_noreq2", mem_req, 0);
            return;
        end
        for (int b = 0; b < nb; b++) begin
            ea = (b == 0) ? v.a0 : v.a1;
            eb = (b == 0) ? v.be0 : v.be1;
            ew = (b == 0) ? v.wd0 : v.wd1;
            check("beat_req", mem_req, 1);
            check("beat_busy", busy, 1);
            check("beat_addr", mem_addr, ea);
            check("beat_be", 32'(mem_be), 32'(eb));
            check("beat_we", mem_we, v.we);
            check("beat_wdata", mem_wdata, ew);
            if (b == 0) begin
                for (int w = 0; w < nwait; w++) begin
                    if (poke && w == 0) begin
                        start = 1'b1; we = 1'b1; modeBU = 3'd1; addr = 32'h999; wdata = 32'h5555;
                    end
                    @(negedge clk);
                    start = 1'b0;
                    check("wait_req", mem_req, 1);
                    check("wait_addr", mem_addr, ea);
                    check("wait_be", 32'(mem_be), 32'(eb));
                    check("wait_done", done, 0);
                end
            end
            mem_ack = 1'b1;
            mem_rdata = (b == 0) ? v.rd0 : v.rd1;
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = 32'h0;
        end
        if (!v.we) prev_rdata = v.rdata;
        check("done", done, 1);
        check("done_err", err, 0);
        check("done_busy", busy, 0);
        check("done_req", mem_req, 0);
        check("rdata", rdata, prev_rdata);
        @(negedge clk);
        check("done_pulse", done, 0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 3'd1, 32'h100, 32'hDEADBEEF, 32'h0, 32'h0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 3'd3, 32'h203, 32'h0, 32'h80123456, 32'h0, 32'h200, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFFFF80, 1'b0};
        vecs[2]  = '{1'b0, 3'd5, 32'h203, 32'h0, 32'h80123456, 32'h0, 32'h200, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 32'h00000080, 1'b0};
        vecs[3]  = '{1'b0, 3'd4, 32'h003, 32'h0, 32'hAA000000, 32'h000000BB, 32'h0, 4'h8, 32'h0, 32'h4, 4'h1, 32'h0, 32'h0000BBAA, 1'b0};
        vecs[4]  = '{1'b1, 3'd2, 32'hFFFFFFFF, 32'h1234, 32'h0, 32'h0, 32'hFFFFFFFC, 4'h8, 32'h34000000, 32'h0, 4'h1, 32'h00000012, 32'h0, 1'b0};
        vecs[5]  = '{1'b0, 3'd1, 32'h104, 32'h0, 32'hCAFEF00D, 32'h0, 32'h104, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0};
        vecs[6]  = '{1'b0, 3'd2, 32'h102, 32'h0, 32'h80011234, 32'h0, 32'h100, 4'hC, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFF8001, 1'b0};
        vecs[7]  = '{1'b0, 3'd2, 32'h201, 32'h0, 32'h00FF7F00, 32'h0, 32'h200, 4'h6, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFFFF7F, 1'b0};
        vecs[8]  = '{1'b0, 3'd1, 32'h006, 32'h0, 32'h33441111, 32'h22225566, 32'h4, 4'hC, 32'h0, 32'h8, 4'h3, 32'h0, 32'h55663344, 1'b0};
        vecs[9]  = '{1'b1, 3'd3, 32'h001, 32'hA5, 32'h0, 32'h0, 32'h0, 4'h2, 32'h0000A500, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0};
        vecs[10] = '{1'b1, 3'd1, 32'h00A, 32'h11223344, 32'h0, 32'h0, 32'h8, 4'hC, 32'h33440000, 32'hC, 4'h3, 32'h00001122, 32'h0, 1'b0};
        vecs[11] = '{1'b0, 3'd0, 32'h50, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1};
        vecs[12] = '{1'b1, 3'd6, 32'h54, 32'h77, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1};
        vecs[13] = '{1'b0, 3'd7, 32'h58, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1};
        vecs[14] = '{1'b0, 3'd5, 32'h300, 32'h0, 32'h123456F0, 32'h0, 32'h300, 4'h1, 32'h0, 32'h0, 4'h0, 32'h0, 32'h000000F0, 1'b0};
        vecs[15] = '{1'b0, 3'd3, 32'h301, 32'h0, 32'h00007F00, 32'h0, 32'h300, 4'h2, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0000007F, 1'b0};

        rst_n = 1'b0; start = 1'b0; we = 1'b0; modeBU = 3'd0; addr = 32'h0; wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        check("rst_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_be", 32'(mem_be), 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_we", mem_we, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run_txn(vecs[i], 0, 1'b0);

        // Wait states on a split load, and a start pulse that must be ignored while busy.
        run_txn(vecs[8], 1, 1'b0);
        run_txn(vecs[5], 2, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("ignored_req", mem_req, 0);
            check("ignored_done", done, 0);
        end

        // Reset in the middle of a stalled beat.
        @(negedge clk);
        start = 1'b1; we = 1'b1; modeBU = 3'd1; addr = 32'h40; wdata = 32'hA5A5A5A5;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            check("stall_req", mem_req, 1);
            check("stall_addr", mem_addr, 32'h40);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", mem_req, 0);
        check("arst_we", mem_we, 0);
        check("arst_addr", mem_addr, 0);
        check("arst_be", 32'(mem_be), 0);
        check("arst_wdata", mem_wdata, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        check("arst_rdata", rdata, 0);
        prev_rdata = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(vecs[3], 0, 1'b0);
        run_txn(vecs[4], 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
